// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin arbiter sharing one binary-to-BCD engine among N_REQ requesters,
// with a per-conversion timeout that answers the requester with an error instead of hanging.
module bcd_conv_scheduler #(
  parameter int N_REQ   = 3,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_bin,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [11:0]        rsp_bcd,
  output logic               rsp_err,
  output logic               busy,
  output logic               cv_start,
  output logic [WIDTH-1:0]   cv_a,
  input  logic               cv_done,
  input  logic [3:0]         cv_ones,
  input  logic [3:0]         cv_tens,
  input  logic [3:0]         cv_hundreds
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] last_gnt_q, last_gnt_d;
  logic [N_REQ-1:0] idx_q, idx_d, req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [11:0] rsp_bcd_q, rsp_bcd_d;
  logic rsp_err_q, rsp_err_d, busy_q, busy_d, cv_start_q, cv_start_d;
  logic [WIDTH-1:0] cv_a_q, cv_a_d;
  logic found_hi;
  logic [IW-1:0] win_hi, win_lo, win;
  logic [N_REQ-1:0] gnt_hi, gnt_lo, gnt;
  logic [WIDTH-1:0] op_hi, op_lo, op;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      last_gnt_q  <= IW'(N_REQ - 1);
      idx_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_bcd_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cv_start_q  <= 1'b0;
      cv_a_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_gnt_q  <= last_gnt_d;
      idx_q       <= idx_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bcd_q   <= rsp_bcd_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cv_start_q  <= cv_start_d;
      cv_a_q      <= cv_a_d;
    end
  end
  // Rotating priority: lowest requester above last_gnt wins, else lowest at or below it.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    gnt_hi   = '0;
    gnt_lo   = '0;
    op_hi    = '0;
    op_lo    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IW'(i) > last_gnt_q) begin
          found_hi  = 1'b1;
          win_hi    = IW'(i);
          gnt_hi    = '0;
          gnt_hi[i] = 1'b1;
          op_hi     = req_bin[i*WIDTH +: WIDTH];
        end else begin
          win_lo    = IW'(i);
          gnt_lo    = '0;
          gnt_lo[i] = 1'b1;
          op_lo     = req_bin[i*WIDTH +: WIDTH];
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
    gnt = found_hi ? gnt_hi : gnt_lo;
    op  = found_hi ? op_hi : op_lo;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? ((|req_valid) ? WAIT : IDLE)
                                : ((cv_done || timer_q == TMAX) ? IDLE : WAIT);
  end
  // A done arriving together with the last timer tick takes precedence over the timeout.
  always_comb begin
    idx_d       = idx_q;
    last_gnt_d  = last_gnt_q;
    cv_a_d      = cv_a_q;
    timer_d     = timer_q;
    busy_d      = busy_q;
    rsp_bcd_d   = rsp_bcd_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    cv_start_d  = 1'b0;
    if (state_q == IDLE) begin
      if (|req_valid) begin
        idx_d       = gnt;
        last_gnt_d  = win;
        cv_a_d      = op;
        req_ready_d = gnt;
        cv_start_d  = 1'b1;
        busy_d      = 1'b1;
        timer_d     = '0;
      end
    end else if (cv_done) begin
      rsp_bcd_d   = {cv_hundreds, cv_tens, cv_ones};
      rsp_err_d   = 1'b0;
      rsp_valid_d = idx_q;
      busy_d      = 1'b0;
    end else begin
      timer_d = timer_q + 1'b1;
      if (timer_q == TMAX) begin
        rsp_bcd_d   = '0;
        rsp_err_d   = 1'b1;
        rsp_valid_d = idx_q;
        busy_d      = 1'b0;
      end
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bcd   = rsp_bcd_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign cv_start  = cv_start_q;
  assign cv_a      = cv_a_q;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: directed table, corner sequences and random traffic against a
// transaction-level model of the scheduler, with an engine stub of programmable latency.
module tb_bcd_conv_scheduler;
  localparam int N = 3, W = 8, TO = 64;
  logic clk = 1'b0, reset;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_bin;
  logic [11:0] rsp_bcd;
  logic rsp_err, busy, cv_start, cv_done;
  logic [W-1:0] cv_a;
  logic [3:0] cv_ones, cv_tens, cv_hundreds;
  logic [W-1:0] bin [N];
  assign req_bin = {bin[2], bin[1], bin[0]};
  always #5 clk = ~clk;
  bcd_conv_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd), .rsp_err(rsp_err),
    .busy(busy), .cv_start(cv_start), .cv_a(cv_a), .cv_done(cv_done),
    .cv_ones(cv_ones), .cv_tens(cv_tens), .cv_hundreds(cv_hundreds)
  );
  int errors = 0, checks = 0, cyc = 0, cnt = 0, cur_lat = 27, model_last = N - 1;
  int exp_idx, exp_cyc, gs, rs;
  logic [W-1:0] eng_op, op;
  logic [11:0] exp_bcd;
  logic exp_err, pend = 1'b0, idle_prev = 1'b0, rnd = 1'b0;
  logic [N-1:0] hold = '0;
  int g_log[$], g_cyc[$], r_cyc[$];
  logic [12:0] r_log[$];
  typedef struct packed {
    logic [2:0]  mask;
    logic [23:0] a;
    logic [7:0]  lat;
    logic [1:0]  n;
    logic [5:0]  gnt;
    logic [35:0] bcd;
    logic        err;
  } vec_t;
  vec_t tv [7];
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic tick();
    int g, w;
    logic gs_seen;
    @(negedge clk);
    cyc++;
    gs_seen = |req_ready;
    g = 0;
    for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (model_last + k) % N;
      if (w < 0 && req_valid[j]) w = j;
    end
    chk("grant_timing", gs_seen, idle_prev && (req_valid != 0));
    chk("rdy_onehot", $onehot0(req_ready), 1);
    chk("rsp_onehot", $onehot0(rsp_valid), 1);
    chk("cv_start", cv_start, gs_seen);
    if (gs_seen) begin
      chk("rr_winner", g, w);
      chk("cv_a_grant", cv_a, bin[g]);
      model_last = g;
      op = bin[g];
      g_log.push_back(g);
      g_cyc.push_back(cyc);
      if (rnd) begin
        int r;
        r = $urandom_range(0, 19);
        cur_lat = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(1, 40);
      end
      pend = 1'b1;
      exp_idx = g;
      if (cur_lat == 0 || cur_lat >= TO) begin
        exp_cyc = cyc + TO; exp_bcd = '0; exp_err = 1'b1;
      end else begin
        exp_cyc = cyc + cur_lat + 1; exp_bcd = to_bcd(int'(op)); exp_err = 1'b0;
      end
      if (!hold[g]) req_valid[g] = 1'b0;
    end
    if (|rsp_valid) begin
      int ri;
      ri = 0;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) ri = i;
      r_log.push_back({rsp_bcd, rsp_err});
      r_cyc.push_back(cyc);
      checks++;
      if (!pend) begin
        errors++;
        $display("FAIL stray_rsp: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        chk("rsp_idx", ri, exp_idx);
        chk("rsp_bcd", rsp_bcd, exp_bcd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_cycle", cyc, exp_cyc);
        pend = 1'b0;
      end
    end
    if (pend && cyc > exp_cyc) begin
      chk("rsp_missing", 0, 1);
      pend = 1'b0;
    end
    chk("busy", busy, pend);
    if (pend) chk("cv_a_stable", cv_a, op);
    cv_done = 1'b0;
    if (reset) cnt = 0;
    else if (cv_start) begin
      cnt = cur_lat;
      eng_op = cv_a;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        cv_done = 1'b1;
        {cv_hundreds, cv_tens, cv_ones} = to_bcd(int'(eng_op));
      end
    end
    idle_prev = !pend && !reset;
  endtask
  task automatic run_until_quiet();
    int n;
    n = 0;
    while ((req_valid != 0 || pend || cnt != 0) && n < 600) begin
      tick();
      n++;
    end
    chk("quiet_bound", n < 600, 1);
    repeat (3) tick();
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0] = '{3'b111, {8'd200, 8'd42, 8'd1}, 8'd27, 2'd3, {2'd2, 2'd1, 2'd0}, {12'h200, 12'h042, 12'h001}, 1'b0};
    tv[1] = '{3'b110, {8'd7, 8'd88, 8'd0},   8'd27, 2'd2, {2'd0, 2'd2, 2'd1}, {12'h000, 12'h007, 12'h088}, 1'b0};
    tv[2] = '{3'b001, {8'd0, 8'd0, 8'd255},  8'd27, 2'd1, {2'd0, 2'd0, 2'd0}, {12'h000, 12'h000, 12'h255}, 1'b0};
    tv[3] = '{3'b010, {8'd0, 8'd77, 8'd0},   8'd0,  2'd1, {2'd0, 2'd0, 2'd1}, {12'h000, 12'h000, 12'h000}, 1'b1};
    tv[4] = '{3'b100, {8'd123, 8'd0, 8'd0},  8'd63, 2'd1, {2'd0, 2'd0, 2'd2}, {12'h000, 12'h000, 12'h123}, 1'b0};
    tv[5] = '{3'b001, {8'd0, 8'd0, 8'd9},    8'd64, 2'd1, {2'd0, 2'd0, 2'd0}, {12'h000, 12'h000, 12'h000}, 1'b1};
    tv[6] = '{3'b101, {8'd99, 8'd0, 8'd10},  8'd1,  2'd2, {2'd0, 2'd0, 2'd2}, {12'h000, 12'h010, 12'h099}, 1'b0};
    reset = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) bin[i] = '0;
    cv_done = 1'b0;
    {cv_hundreds, cv_tens, cv_ones} = '0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_bcd", rsp_bcd, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cv_start", cv_start, 0);
    chk("rst_cv_a", cv_a, 0);
    reset = 1'b0;
    idle_prev = 1'b1;
    for (int e = 0; e < 7; e++) begin
      gs = g_log.size();
      rs = r_log.size();
      cur_lat = int'(tv[e].lat);
      for (int i = 0; i < N; i++) bin[i] = tv[e].a[i*8 +: 8];
      req_valid = tv[e].mask;
      run_until_quiet();
      chk("tbl_n_grants", g_log.size() - gs, int'(tv[e].n));
      chk("tbl_n_rsps", r_log.size() - rs, int'(tv[e].n));
      for (int k = 0; k < int'(tv[e].n); k++) begin
        if (gs + k < g_log.size()) chk("tbl_grant", g_log[gs+k], int'(tv[e].gnt[2*k +: 2]));
        if (rs + k < r_log.size()) chk("tbl_rsp", int'(r_log[rs+k]), int'({tv[e].bcd[12*k +: 12], tv[e].err}));
      end
    end
    // Reset in the middle of a conversion: nothing must come back for the aborted request.
    cur_lat = 27;
    bin[0] = 8'd50;
    req_valid = 3'b001;
    for (int n = 0; n < 20 && !pend; n++) tick();
    chk("rst_mid_granted", pend, 1);
    for (int n = 0; n < 20 && cyc < g_cyc[$] + 10; n++) tick();
    reset = 1'b1;
    #1;
    chk("rstw_req_ready", req_ready, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_rsp_bcd", rsp_bcd, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_cv_start", cv_start, 0);
    chk("rstw_cv_a", cv_a, 0);
    pend = 1'b0;
    idle_prev = 1'b0;
    cnt = 0;
    req_valid = '0;
    model_last = N - 1;
    rs = r_log.size();
    repeat (3) tick();
    reset = 1'b0;
    idle_prev = 1'b1;
    repeat (60) tick();
    chk("rst_no_rsp", r_log.size(), rs);
    bin[0] = 8'd128;
    req_valid = 3'b001;
    run_until_quiet();
    chk("rst_after_rsp", int'(r_log[$]), int'({12'h128, 1'b0}));
    // Back-to-back on one requester holding req_valid across its response.
    gs = g_log.size();
    rs = r_log.size();
    hold = 3'b001;
    bin[0] = 8'd0;
    req_valid = 3'b001;
    for (int n = 0; n < 100 && g_log.size() < gs + 1; n++) tick();
    bin[0] = 8'd99;
    for (int n = 0; n < 100 && g_log.size() < gs + 2; n++) tick();
    req_valid = '0;
    hold = '0;
    run_until_quiet();
    chk("b2b_grants", g_log.size() - gs, 2);
    chk("b2b_rsps", r_log.size() - rs, 2);
    if (r_log.size() >= rs + 2 && g_log.size() >= gs + 2) begin
      chk("b2b_first", int'(r_log[rs]), int'({12'h000, 1'b0}));
      chk("b2b_second", int'(r_log[rs+1]), int'({12'h099, 1'b0}));
      chk("b2b_regrant", g_cyc[gs+1], r_cyc[rs] + 1);
    end
    rnd = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          bin[i] = W'($urandom);
          if ($urandom_range(0, 5) == 0) req_valid[i] = 1'b1;
        end
      end
    end
    rnd = 1'b0;
    cur_lat = 27;
    run_until_quiet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
